// File: rtl/int_ctrl_pkg.sv
// Shared types, register offsets and bit positions for the interrupt controller.
package int_ctrl_pkg;

    // Controller FSM; the encoding is visible to software through STATUS.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    // Register window offsets (reg_sel).
    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_ACTIVE  = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // ACTIVE: {28'b0, busy, active_id}
    localparam int ACTIVE_ID_LSB   = 0;
    localparam int ACTIVE_BUSY_BIT = 3;

    // STATUS: {29'b0, state[1:0], int_req}
    localparam int STATUS_REQ_BIT   = 0;
    localparam int STATUS_STATE_LSB = 1;

    // Lowest set index of an 8-bit vector; 0 when the vector is empty.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer plus edge register for one asynchronous interrupt line.
// edge_o is a one-cycle pulse on a synchronised rising edge.
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    output logic edge_o
);

    logic s1_q, s2_q, s3_q;

    // Synchronizer chain and edge-detect history, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= irq_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/int_controller.sv
// Prioritised, non-nesting interrupt controller: pending/mask registers,
// lowest-index-wins selection, request/ack/rfe FSM and a small register window.
// Handshake: int_req stays high from the IDLE->REQ edge until the edge that
// samples int_ack; int_ack counts only in REQ and rfe only in SERVICE.
module int_controller
    import int_ctrl_pkg::*;
#(
    parameter int          N_SRC      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0008
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    output logic             int_req,
    output logic [31:0]      int_vector,
    input  logic             int_ack,
    input  logic             rfe,
    output logic [2:0]       active_id,
    input  logic [1:0]       reg_sel,
    input  logic             reg_wr,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata
);

    state_e             state_q, state_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [2:0]         active_id_q, active_id_d;
    logic [31:0]        vector_q, vector_d;
    logic               int_req_q, int_req_d;
    logic [N_SRC-1:0]   edge_w;
    logic [7:0]         pend_en;
    logic [7:0]         ack_clr;
    logic [N_SRC-1:0]   w1c;
    logic               busy;
    logic               unused_wdata;

    assign unused_wdata = ^reg_wdata;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        irq_sync_edge u_sync (
            .clk    (clk),
            .rst    (rst),
            .irq_i  (irq_in[i]),
            .edge_o (edge_w[i])
        );
    end

    // FSM next state; the winning source and its vector are frozen on IDLE->REQ.
    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        vector_d    = vector_q;
        ack_clr     = '0;
        pend_en     = '0;
        pend_en[N_SRC-1:0] = pending_q & mask_q;
        case (state_q)
            ST_IDLE: begin
                if (|pend_en) begin
                    active_id_d = lowest_idx(pend_en);
                    vector_d    = VEC_BASE + 32'(active_id_d) * VEC_STRIDE;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    ack_clr[active_id_q] = 1'b1;
                    state_d              = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (rfe) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        int_req_d = (state_d == ST_REQ);
    end

    // Pending/mask update; a fresh edge always beats a W1C or ack clear.
    always_comb begin
        w1c       = (reg_wr && reg_sel == REG_PENDING) ? reg_wdata[N_SRC-1:0] : '0;
        pending_d = (pending_q & ~w1c & ~ack_clr[N_SRC-1:0]) | edge_w;
        mask_d    = (reg_wr && reg_sel == REG_MASK) ? reg_wdata[N_SRC-1:0] : mask_q;
    end

    // State and register file, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            mask_q      <= '0;
            active_id_q <= 3'd0;
            vector_q    <= VEC_BASE;
            int_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            active_id_q <= active_id_d;
            vector_q    <= vector_d;
            int_req_q   <= int_req_d;
        end
    end

    assign busy       = (state_q == ST_SERVICE);
    assign int_req    = int_req_q;
    assign int_vector = vector_q;
    assign active_id  = active_id_q;

    // Combinational register read mux; unused upper bits read 0.
    always_comb begin
        reg_rdata = 32'd0;
        case (reg_sel)
            REG_PENDING: reg_rdata = 32'(pending_q);
            REG_MASK:    reg_rdata = 32'(mask_q);
            REG_ACTIVE: begin
                reg_rdata[ACTIVE_ID_LSB +: 3] = active_id_q;
                reg_rdata[ACTIVE_BUSY_BIT]    = busy;
            end
            REG_STATUS: begin
                reg_rdata[STATUS_REQ_BIT]        = int_req_q;
                reg_rdata[STATUS_STATE_LSB +: 2] = state_q;
            end
            default: reg_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_int_controller.sv
// Directed self-checking bench for int_controller (default parameters).
module tb_int_controller;

    logic        clk;
    logic        rst;
    logic [3:0]  irq_in;
    logic        int_req;
    logic [31:0] int_vector;
    logic        int_ack;
    logic        rfe;
    logic [2:0]  active_id;
    logic [1:0]  reg_sel;
    logic        reg_wr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    int_controller dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .int_req    (int_req),
        .int_vector (int_vector),
        .int_ack    (int_ack),
        .rfe        (rfe),
        .active_id  (active_id),
        .reg_sel    (reg_sel),
        .reg_wr     (reg_wr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance n edges; sample point is 1ns after each rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_write(input logic [1:0] sel, input logic [31:0] data);
        reg_sel   = sel;
        reg_wdata = data;
        reg_wr    = 1'b1;
        step(1);
        reg_wr    = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        reg_sel = sel;
        #1;
        check(tag, reg_rdata, exp);
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
    endtask

    task automatic pulse_rfe();
        rfe = 1'b1;
        step(1);
        rfe = 1'b0;
    endtask

    // STATUS encodings: {state, int_req}
    localparam logic [31:0] ST_IDLE_V = 32'd0;
    localparam logic [31:0] ST_REQ_V  = 32'd3;
    localparam logic [31:0] ST_SVC_V  = 32'd4;

    initial begin
        rst = 1'b0; irq_in = '0; int_ack = 1'b0; rfe = 1'b0;
        reg_sel = 2'd0; reg_wr = 1'b0; reg_wdata = '0;
        step(2);
        rst = 1'b1;
        step(1);

        // Reset state
        check("rst_int_req", 32'(int_req), 32'd0);
        check("rst_vector", int_vector, 32'h100);
        check("rst_active_id", 32'(active_id), 32'd0);
        check_reg("rst_pending", 2'd0, 32'd0);
        check_reg("rst_mask", 2'd1, 32'd0);
        check_reg("rst_status", 2'd3, ST_IDLE_V);

        // Basic request on source 1
        reg_write(2'd1, 32'h2);
        irq_in[1] = 1'b1;
        step(1);
        check("basic_req_k0", 32'(int_req), 32'd0);
        step(1);
        check("basic_req_k1", 32'(int_req), 32'd0);
        step(1);
        irq_in[1] = 1'b0;
        check("basic_req_k2", 32'(int_req), 32'd0);
        check_reg("basic_pending_set", 2'd0, 32'h2);
        step(1);
        check("basic_req_k3", 32'(int_req), 32'd1);
        check("basic_id", 32'(active_id), 32'd1);
        check("basic_vector", int_vector, 32'h108);
        check_reg("basic_status_req", 2'd3, ST_REQ_V);
        pulse_ack();
        check("basic_req_drop", 32'(int_req), 32'd0);
        check_reg("basic_pending_clr", 2'd0, 32'd0);
        check_reg("basic_status_svc", 2'd3, ST_SVC_V);
        check_reg("basic_active", 2'd2, 32'h9);
        pulse_rfe();
        check_reg("basic_status_idle", 2'd3, ST_IDLE_V);
        check_reg("basic_active_hold", 2'd2, 32'h1);
        step(3);

        // Priority: sources 3 and 2 together
        reg_write(2'd1, 32'hF);
        irq_in = 4'b1100;
        step(4);
        irq_in = '0;
        check("prio_req", 32'(int_req), 32'd1);
        check("prio_id", 32'(active_id), 32'd2);
        check("prio_vector", int_vector, 32'h110);
        check_reg("prio_pending", 2'd0, 32'hC);
        pulse_ack();
        check_reg("prio_pending_ack", 2'd0, 32'h8);
        pulse_rfe();
        check("prio_idle_req", 32'(int_req), 32'd0);
        step(1);
        check("prio_second_req", 32'(int_req), 32'd1);
        check("prio_second_id", 32'(active_id), 32'd3);
        check("prio_second_vector", int_vector, 32'h118);
        pulse_ack();
        pulse_rfe();
        check_reg("prio_pending_empty", 2'd0, 32'd0);
        step(2);

        // Masked then unmasked on source 0
        reg_write(2'd1, 32'h0);
        irq_in[0] = 1'b1;
        step(3);
        irq_in[0] = 1'b0;
        check_reg("mask_pending", 2'd0, 32'h1);
        for (int i = 0; i < 10; i++) begin
            check("mask_no_req", 32'(int_req), 32'd0);
            step(1);
        end
        reg_write(2'd1, 32'h1);
        check("unmask_no_req_yet", 32'(int_req), 32'd0);
        step(1);
        check("unmask_req", 32'(int_req), 32'd1);
        check("unmask_vector", int_vector, 32'h100);
        pulse_ack();
        pulse_rfe();
        step(2);

        // W1C colliding with a new edge on source 0
        reg_write(2'd1, 32'h0);
        irq_in[0] = 1'b1;
        step(3);
        irq_in[0] = 1'b0;
        step(3);
        check_reg("w1c_pre", 2'd0, 32'h1);
        irq_in[0] = 1'b1;
        step(2);
        reg_write(2'd0, 32'h1);
        check_reg("w1c_edge_wins", 2'd0, 32'h1);
        irq_in[0] = 1'b0;
        step(3);
        reg_write(2'd0, 32'h1);
        check_reg("w1c_alone", 2'd0, 32'h0);

        // Edge on active source in the same cycle as int_ack
        reg_write(2'd1, 32'h1);
        irq_in[0] = 1'b1;
        step(4);
        irq_in[0] = 1'b0;
        check("ackcol_req", 32'(int_req), 32'd1);
        step(3);
        irq_in[0] = 1'b1;
        step(2);
        pulse_ack();
        irq_in[0] = 1'b0;
        check_reg("ackcol_pending", 2'd0, 32'h1);
        check_reg("ackcol_status", 2'd3, ST_SVC_V);
        pulse_rfe();
        step(1);
        check("ackcol_rereq", 32'(int_req), 32'd1);
        check("ackcol_id", 32'(active_id), 32'd0);
        // Software clear during REQ keeps the request
        reg_write(2'd0, 32'h1);
        check("req_survives_w1c", 32'(int_req), 32'd1);
        pulse_ack();
        pulse_rfe();
        check_reg("ackcol_done", 2'd3, ST_IDLE_V);
        step(3);

        // Spurious handshakes
        pulse_rfe();
        check_reg("spur_rfe_idle", 2'd3, ST_IDLE_V);
        pulse_ack();
        check_reg("spur_ack_idle", 2'd3, ST_IDLE_V);
        reg_write(2'd1, 32'h3);
        irq_in[1] = 1'b1;
        step(4);
        irq_in[1] = 1'b0;
        check_reg("spur_req", 2'd3, ST_REQ_V);
        pulse_rfe();
        check_reg("spur_rfe_req", 2'd3, ST_REQ_V);
        pulse_ack();
        check_reg("spur_svc", 2'd3, ST_SVC_V);
        pulse_ack();
        check_reg("spur_ack_svc", 2'd3, ST_SVC_V);
        check("spur_id", 32'(active_id), 32'd1);

        // Reset while in SERVICE
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        check("mid_rst_int_req", 32'(int_req), 32'd0);
        check("mid_rst_vector", int_vector, 32'h100);
        check("mid_rst_id", 32'(active_id), 32'd0);
        check_reg("mid_rst_mask", 2'd1, 32'd0);
        check_reg("mid_rst_status", 2'd3, ST_IDLE_V);
        check_reg("mid_rst_active", 2'd2, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
